mem_wb: RTL
===========

# mem_wb

Pipeline register between the memory-access stage and write-back in the five-stage MIPS core. It captures the GPR write request (`waddr`/`we`/`wdata`), the HI/LO write request and the LLbit update from the memory stage on each clock edge. It presents them to the register file, HI/LO unit and LLbit register one cycle later. It implements the core's stall, bubble and flush rules, and maintains a retired-instruction counter.

## Interface
- No parameters; widths come from `defines.v` (`RegAddrBus` = 5 bits, `RegBus` = 32 bits).
- `clk` input 1: core clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset (asserted at 0).
- `mem_waddr` input 5: GPR destination from the memory stage.
- `mem_we` input 1: GPR write enable.
- `mem_wdata` input 32: GPR write data.
- `mem_whilo` input 1: HI/LO write enable.
- `mem_hi` input 32: HI write data.
- `mem_lo` input 32: LO write data.
- `mem_LLbit_we` input 1: LLbit write enable.
- `mem_LLbit_value` input 1: LLbit write value.
- `mem_valid` input 1: the memory stage holds a real instruction, not a bubble.
- `stall` input 6: core stall vector; bit 4 is the memory stage, bit 5 is write-back.
- `flush` input 1: exception flush from the control unit.
- `wb_waddr`, `wb_we`, `wb_wdata`: outputs 5/1/32, registered GPR write request.
- `wb_whilo`, `wb_hi`, `wb_lo`: outputs 1/32/32, registered HI/LO write request.
- `wb_LLbit_we`, `wb_LLbit_value`: outputs 1/1, registered LLbit update.
- `wb_valid` output 1: the write-back slot holds a real instruction.
- `retire_cnt` output 32: number of instructions retired since reset.

## Operation
- The block holds one stage slot: every `wb_*` output is a flop.
- Each rising edge with `rst`=1 applies the first matching rule below.
- Priority 1, flush: `flush`=1 loads the bubble value.
- Priority 2, bubble insert: `stall[4]`=1 and `stall[5]`=0 load the bubble value.
- Priority 3, advance: `stall[4]`=0 captures all `mem_*` inputs, with `wb_valid` <= `mem_valid`.
- Priority 4, hold: any other case keeps the slot unchanged. This covers `stall[4]`=1 with `stall[5]`=1.
- Bubble value:
  - `wb_waddr`=`NOPRegAddr` (0), `wb_we`=`WriteDisable`, `wb_wdata`=`ZeroWord`.
  - `wb_whilo`=0, `wb_hi`=`wb_lo`=0.
  - `wb_LLbit_we`=0, `wb_LLbit_value`=0.
  - `wb_valid`=0.
- The capture path does not transform the data. A write to `$0` passes through unchanged; the register file ignores it.
- Retire counter:
  - `retire_cnt` increments by 1 on every edge where `wb_valid`=1 and `stall[5]`=0, meaning the slot's instruction leaves write-back.
  - The counter is 32-bit unsigned and wraps from 0xFFFFFFFF to 0 with no flag.
  - `flush` does not clear the counter.
  - On a flush edge the current slot still counts if it was valid and `stall[5]`=0. The flush discards the incoming instruction, not the retiring one.

## Timing
- Latency: inputs present before edge N appear on outputs after edge N (1 cycle).
- Reset:
  - `rst` falling to 0 forces every output to its bubble value and `retire_cnt` to 0 immediately, without waiting for `clk`.
  - Outputs stay there while `rst`=0.
  - The first capture happens on the first rising edge after `rst` returns to 1.
- Reset mid-operation discards the slot; the instruction in it is not counted.
- Simultaneous `flush` and `stall[4]`=1 with `stall[5]`=1: flush wins and the slot becomes a bubble.
- Outputs hold stable for the whole cycle; there are no combinational paths from input to output.
- Back-to-back captures every cycle are supported; throughput is 1 instruction per clock.

## Test plan
- Reset:
  - Drive `rst`=0 asynchronously mid-cycle with the slot holding `waddr`=5, `wdata`=0x12345678 and `retire_cnt`=7.
  - Required: all outputs go to 0 before the next `clk` edge and `retire_cnt`=0.
- Pass-through:
  - With `stall`=0 and `mem_valid`=1, present `waddr`=3, `we`=1, `wdata`=0xDEADBEEF, `whilo`=1, `hi`=0x1, `lo`=0x2.
  - Required: after one edge the `wb_*` outputs match exactly and `wb_valid`=1.
  - Required: `retire_cnt` increments on the following edge.
- Stall hold:
  - Set `stall`=6'b111111 for 3 cycles while the inputs change.
  - Required: outputs stay frozen at the prior values and `retire_cnt` does not change.
- Bubble insert:
  - Set `stall`=6'b011111 with `we`=1 on the input.
  - Required: after the edge `wb_we`=0, `wb_waddr`=0 and `wb_valid`=0.
  - Required: the next cycle adds no count.
- Flush priority:
  - With the slot valid, assert `flush`=1 together with `stall`=6'b111111.
  - Required: the slot becomes a bubble and `retire_cnt` does not increment, because `stall[5]`=1.
  - Repeat with `stall`=0: the counter increments by 1 and the slot becomes a bubble.
- Counter wrap:
  - Force `retire_cnt` to 0xFFFFFFFF, then retire one valid instruction.
  - Required: `retire_cnt`=0x00000000.

Source files
------------

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: one stage slot carrying the GPR, HI/LO and LLbit
// write requests into write-back, plus a retired-instruction counter.
module mem_wb (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  mem_waddr,
   input  logic        mem_we,
   input  logic [31:0] mem_wdata,
   input  logic        mem_whilo,
   input  logic [31:0] mem_hi,
   input  logic [31:0] mem_lo,
   input  logic        mem_LLbit_we,
   input  logic        mem_LLbit_value,
   input  logic        mem_valid,
   input  logic [5:0]  stall,
   input  logic        flush,
   output logic [4:0]  wb_waddr,
   output logic        wb_we,
   output logic [31:0] wb_wdata,
   output logic        wb_whilo,
   output logic [31:0] wb_hi,
   output logic [31:0] wb_lo,
   output logic        wb_LLbit_we,
   output logic        wb_LLbit_value,
   output logic        wb_valid,
   output logic [31:0] retire_cnt
);

   logic [4:0]  wb_waddr_q, wb_waddr_d;
   logic        wb_we_q, wb_we_d;
   logic [31:0] wb_wdata_q, wb_wdata_d;
   logic        wb_whilo_q, wb_whilo_d;
   logic [31:0] wb_hi_q, wb_hi_d;
   logic [31:0] wb_lo_q, wb_lo_d;
   logic        wb_LLbit_we_q, wb_LLbit_we_d;
   logic        wb_LLbit_value_q, wb_LLbit_value_d;
   logic        wb_valid_q, wb_valid_d;
   logic [31:0] retire_cnt_q, retire_cnt_d;

   logic        load_bubble;
   logic        advance;
   logic        retire;
   logic        unused_stall_bits;

   assign unused_stall_bits = ^stall[3:0];

   // Flush outranks everything; a stalled memory stage with a moving
   // write-back stage must leave a bubble behind.
   assign load_bubble = flush || (stall[4] && !stall[5]);
   assign advance     = !stall[4];
   assign retire      = wb_valid_q && !stall[5];

   always_comb begin
      wb_waddr_d       = wb_waddr_q;
      wb_we_d          = wb_we_q;
      wb_wdata_d       = wb_wdata_q;
      wb_whilo_d       = wb_whilo_q;
      wb_hi_d          = wb_hi_q;
      wb_lo_d          = wb_lo_q;
      wb_LLbit_we_d    = wb_LLbit_we_q;
      wb_LLbit_value_d = wb_LLbit_value_q;
      wb_valid_d       = wb_valid_q;
      if (load_bubble) begin
         wb_waddr_d       = 5'd0;
         wb_we_d          = 1'b0;
         wb_wdata_d       = 32'd0;
         wb_whilo_d       = 1'b0;
         wb_hi_d          = 32'd0;
         wb_lo_d          = 32'd0;
         wb_LLbit_we_d    = 1'b0;
         wb_LLbit_value_d = 1'b0;
         wb_valid_d       = 1'b0;
      end else if (advance) begin
         wb_waddr_d       = mem_waddr;
         wb_we_d          = mem_we;
         wb_wdata_d       = mem_wdata;
         wb_whilo_d       = mem_whilo;
         wb_hi_d          = mem_hi;
         wb_lo_d          = mem_lo;
         wb_LLbit_we_d    = mem_LLbit_we;
         wb_LLbit_value_d = mem_LLbit_value;
         wb_valid_d       = mem_valid;
      end
   end

   // The retiring slot counts even on a flush edge; only the incoming one dies.
   always_comb begin
      retire_cnt_d = retire_cnt_q + {31'd0, retire};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_waddr_q       <= 5'd0;
         wb_we_q          <= 1'b0;
         wb_wdata_q       <= 32'd0;
         wb_whilo_q       <= 1'b0;
         wb_hi_q          <= 32'd0;
         wb_lo_q          <= 32'd0;
         wb_LLbit_we_q    <= 1'b0;
         wb_LLbit_value_q <= 1'b0;
         wb_valid_q       <= 1'b0;
         retire_cnt_q     <= 32'd0;
      end else begin
         wb_waddr_q       <= wb_waddr_d;
         wb_we_q          <= wb_we_d;
         wb_wdata_q       <= wb_wdata_d;
         wb_whilo_q       <= wb_whilo_d;
         wb_hi_q          <= wb_hi_d;
         wb_lo_q          <= wb_lo_d;
         wb_LLbit_we_q    <= wb_LLbit_we_d;
         wb_LLbit_value_q <= wb_LLbit_value_d;
         wb_valid_q       <= wb_valid_d;
         retire_cnt_q     <= retire_cnt_d;
      end
   end

   assign wb_waddr       = wb_waddr_q;
   assign wb_we          = wb_we_q;
   assign wb_wdata       = wb_wdata_q;
   assign wb_whilo       = wb_whilo_q;
   assign wb_hi          = wb_hi_q;
   assign wb_lo          = wb_lo_q;
   assign wb_LLbit_we    = wb_LLbit_we_q;
   assign wb_LLbit_value = wb_LLbit_value_q;
   assign wb_valid       = wb_valid_q;
   assign retire_cnt     = retire_cnt_q;

endmodule
